// File: rtl/wb_burst_writer.sv
// wb_burst_writer
// Buffers 512-bit result beats from the write-back controller and sends them
// to external memory as sequential AXI4-style write bursts, starting at an
// aligned base address. Only one burst is outstanding at a time, and the
// address phase of a burst starts only when all of its data is already held
// in the internal FIFO.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle job start (only honoured when idle)
//   cfg_base_addr         job base byte address (sampled on start)
//   cfg_total_beats       job length in beats (sampled on start)
//   in_data, in_valid     incoming beat stream (no backpressure)
//   awaddr/awlen/awvalid/awready   write address channel
//   wdata/wvalid/wready/wlast      write data channel
//   bvalid/bresp/bready            write response channel
//   busy                  job in progress
//   done                  one-cycle job completion pulse
//   err_overflow          sticky: an incoming beat was dropped
//   err_resp              sticky: a non-OKAY write response was received
module wb_burst_writer #(
  parameter int ADDR_W     = 64,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_total_beats,
  input  logic [511:0]      in_data,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [511:0]      wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_resp
);

  localparam int DATA_W  = 512;
  localparam int BEAT_SH = $clog2(DATA_W / 8);
  localparam int ALIGN_W = $clog2(BURST_LEN * (DATA_W / 8));
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FCNT_W  = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~((ADDR_W'(1) << ALIGN_W) - ADDR_W'(1));

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, ADDR, DATA, RESP, DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FCNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]    acc_rem;
  logic [CNT_W-1:0]    iss_rem;
  logic [CNT_W-1:0]    burst_n;
  logic [ADDR_W-1:0]   cur_addr;
  logic [7:0]          beat_idx;
  logic                fifo_full;
  logic                push;
  logic                pop;

  always_comb begin
    burst_n = iss_rem;
    if (iss_rem >= CNT_W'(BURST_LEN)) burst_n = CNT_W'(BURST_LEN);
  end

  // Full is judged on the pre-pop count, so a simultaneous pop never rescues
  // a push into a full FIFO.
  assign fifo_full = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign push      = in_valid && (state != IDLE) && (acc_rem != '0) && !fifo_full;
  assign pop       = wvalid && wready;

  // Show-ahead head of the FIFO; forced to zero when empty so the bus is
  // clean out of reset and after a flush.
  assign wdata = (fifo_count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      acc_rem      <= '0;
      iss_rem      <= '0;
      cur_addr     <= '0;
      beat_idx     <= '0;
      awaddr       <= '0;
      awlen        <= '0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      wlast        <= 1'b0;
      bready       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      err_resp     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        acc_rem <= acc_rem - CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + FCNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - FCNT_W'(1);
      if (in_valid && !push) err_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            cur_addr     <= cfg_base_addr & ALIGN_MASK;
            acc_rem      <= cfg_total_beats;
            iss_rem      <= cfg_total_beats;
            // A beat arriving in this same cycle is still dropped (idle).
            err_overflow <= in_valid;
            err_resp     <= 1'b0;
            busy         <= 1'b1;
            if (cfg_total_beats == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (CNT_W'(fifo_count) >= burst_n) begin
            awaddr   <= cur_addr;
            awlen    <= 8'(burst_n - CNT_W'(1));
            awvalid  <= 1'b1;
            beat_idx <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wlast   <= (awlen == 8'd0);
            state   <= DATA;
          end
        end
        DATA: begin
          if (wready) begin
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= RESP;
            end else begin
              beat_idx <= beat_idx + 8'd1;
              // The beat after this one is the last when its index equals awlen.
              wlast    <= ((beat_idx + 8'd1) == awlen);
            end
          end
        end
        RESP: begin
          if (bvalid) begin
            bready   <= 1'b0;
            if (bresp != 2'b00) err_resp <= 1'b1;
            cur_addr <= cur_addr + (ADDR_W'(burst_n) << BEAT_SH);
            iss_rem  <= iss_rem - burst_n;
            if (iss_rem == burst_n) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
